// File: rtl/uart_cmd_pkg.sv
// Shared constants and echo FSM encoding for the UART command/echo controller.
package uart_cmd_pkg;

    localparam logic [7:0] CH_0 = 8'h30;
    localparam logic [7:0] CH_1 = 8'h31;
    localparam logic [7:0] CR   = 8'h0D;
    localparam logic [7:0] LF   = 8'h0A;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StSendLf
    } echo_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; caller gates push/pop against full/empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_resetn,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_wdata,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_rdata,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (i_push && !i_pop) begin
                r_level <= r_level + LW'(1);
            end else if (!i_push && i_pop) begin
                r_level <= r_level - LW'(1);
            end
        end
    end

    // Storage needs no reset; occupancy alone defines which entries are valid.
    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = (r_level == LW'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Command/echo controller: decodes received bytes into LED toggles and echoes them on TX.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int unsigned NUM_LEDS       = 5,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter bit          LED_ACTIVE_LOW = 1'b1,
    parameter bit          EXPAND_CR      = 1'b1
) (
    input  logic                        i_clk,
    input  logic                        i_resetn,
    input  logic                        i_rx_valid,
    input  logic [7:0]                  i_rx_data,
    input  logic                        i_rx_err,
    output logic                        o_tx_valid,
    output logic [7:0]                  o_tx_data,
    input  logic                        i_tx_ready,
    output logic [NUM_LEDS-1:0]         o_led,
    output logic [$clog2(FIFO_DEPTH):0] o_fifo_level,
    output logic                        o_ovf_flag,
    output logic                        o_err_flag
);

    echo_state_e         r_state;
    echo_state_e         w_state_nxt;
    logic                r_tx_valid;
    logic                w_tx_valid_nxt;
    logic [7:0]          r_tx_data;
    logic [7:0]          w_tx_data_nxt;
    logic [NUM_LEDS-1:0] r_led;
    logic [NUM_LEDS-1:0] w_led_nxt;
    logic                r_ovf;
    logic                r_err;

    logic       w_rx_good;
    logic       w_is_clear;
    logic       w_is_toggle;
    logic [7:0] w_led_idx;
    logic       w_push;
    logic       w_pop;
    logic       w_full;
    logic       w_empty;
    logic [7:0] w_head;

    assign w_rx_good   = i_rx_valid && !i_rx_err;
    assign w_is_clear  = w_rx_good && (i_rx_data == CH_0);
    // Bytes below '1' wrap to large indices and fall outside the LED range.
    assign w_led_idx   = i_rx_data - CH_1;
    assign w_is_toggle = w_rx_good && (w_led_idx < 8'(NUM_LEDS));
    assign w_push      = w_rx_good && (!w_full || w_pop);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk    (i_clk),
        .i_resetn (i_resetn),
        .i_push   (w_push),
        .i_wdata  (i_rx_data),
        .i_pop    (w_pop),
        .o_rdata  (w_head),
        .o_full   (w_full),
        .o_empty  (w_empty),
        .o_level  (o_fifo_level)
    );

    always_comb begin
        w_led_nxt = r_led;
        if (w_is_clear) begin
            w_led_nxt = '0;
        end else if (w_is_toggle) begin
            for (int unsigned k = 0; k < NUM_LEDS; k++) begin
                if (w_led_idx == 8'(k)) w_led_nxt[k] = ~r_led[k];
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_tx_valid_nxt = r_tx_valid;
        w_tx_data_nxt  = r_tx_data;
        w_pop          = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!w_empty) begin
                    w_pop          = 1'b1;
                    w_tx_data_nxt  = w_head;
                    w_tx_valid_nxt = 1'b1;
                    w_state_nxt    = StSend;
                end
            end
            StSend: begin
                if (i_tx_ready) begin
                    if (EXPAND_CR && (r_tx_data == CR)) begin
                        w_tx_data_nxt = LF;
                        w_state_nxt   = StSendLf;
                    end else begin
                        w_tx_valid_nxt = 1'b0;
                        w_state_nxt    = StIdle;
                    end
                end
            end
            StSendLf: begin
                if (i_tx_ready) begin
                    w_tx_valid_nxt = 1'b0;
                    w_state_nxt    = StIdle;
                end
            end
            default: begin
                w_tx_valid_nxt = 1'b0;
                w_state_nxt    = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state    <= StIdle;
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
            r_led      <= '0;
            r_ovf      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tx_valid <= w_tx_valid_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_led      <= w_led_nxt;
            if (i_rx_valid && i_rx_err)            r_err <= 1'b1;
            if (w_rx_good && w_full && !w_pop)     r_ovf <= 1'b1;
            // A '0' on the same edge as an overflow leaves the flag clear.
            if (w_is_clear) begin
                r_ovf <= 1'b0;
                r_err <= 1'b0;
            end
        end
    end

    assign o_tx_valid = r_tx_valid;
    assign o_tx_data  = r_tx_data;
    assign o_led      = LED_ACTIVE_LOW ? ~r_led : r_led;
    assign o_ovf_flag = r_ovf;
    assign o_err_flag = r_err;

endmodule
